// File: rtl/class_assoc_search.sv
// class_assoc_search: sweeps every class-memory word, forms the signed dot
// product of each class hypervector with the query, and reports the best class.
// Optional macro ASSOC_SCORE_OUT_EN exposes every class's final score as it is compared.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start with write_done high
// S_RUN   | issuing one class/query word address per cycle (re=1)
// S_DRAIN | pipeline emptying, waiting for the last class compare
// S_DONE  | one-cycle done pulse, result registers hold the winner
module class_assoc_search #(
   parameter int FTWIDTH     = 8,
   parameter int M_SIZE      = 16,
   parameter int ADDR_WIDTH  = 13,
   parameter int NUM_CLASSES = 26,
   parameter int DIM         = 4000,
   parameter int ACC_WIDTH   = 32,
   parameter int CLASS_WIDTH = 5
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        write_done,
   input  logic [M_SIZE*FTWIDTH-1:0]   class_out,
   input  logic [M_SIZE*FTWIDTH-1:0]   query_in,
   output logic [ADDR_WIDTH-1:0]       read_address,
   output logic                        re,
   output logic [ADDR_WIDTH-1:0]       query_address,
   output logic                        busy,
   output logic                        done,
   output logic [CLASS_WIDTH-1:0]      pred_class,
   output logic [ACC_WIDTH-1:0]        best_score
`ifdef ASSOC_SCORE_OUT_EN
   ,
   output logic                        score_valid,
   output logic [CLASS_WIDTH-1:0]      score_class,
   output logic [ACC_WIDTH-1:0]        score_value
`endif
);

   localparam int WORDS_PER_CLASS = DIM / M_SIZE;
   localparam int LAST_ADDR       = NUM_CLASSES * WORDS_PER_CLASS - 1;
   localparam int WORD_W          = $clog2(WORDS_PER_CLASS);
   localparam int PROD_W          = 2 * FTWIDTH;
   localparam int SUM_W           = 2 * FTWIDTH + 4;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                        state_q, state_d;
   logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
   logic [WORD_W-1:0]             word_q, word_d;
   logic [CLASS_WIDTH-1:0]        cls_q, cls_d;
   logic                          v1_q, v1_d, first1_q, first1_d, last1_q, last1_d;
   logic [CLASS_WIDTH-1:0]        cls1_q, cls1_d;
   logic                          v2_q, v2_d, first2_q, first2_d, last2_q, last2_d;
   logic [CLASS_WIDTH-1:0]        cls2_q, cls2_d;
   logic signed [SUM_W-1:0]       sum_q, sum_d;
   logic signed [PROD_W-1:0]      prod;
   logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic                          cmp_pend_q, cmp_pend_d;
   logic [CLASS_WIDTH-1:0]        cls3_q, cls3_d;
   logic signed [ACC_WIDTH-1:0]   best_q, best_d;
   logic [CLASS_WIDTH-1:0]        best_cls_q, best_cls_d;
   logic                          cmp_vld_q, cmp_vld_d, cmp_last_q, cmp_last_d;
   logic [CLASS_WIDTH-1:0]        pred_q, pred_d;
   logic [ACC_WIDTH-1:0]          score_q, score_d;
`ifdef ASSOC_SCORE_OUT_EN
   logic [CLASS_WIDTH-1:0]        cmp_cls_q, cmp_cls_d;
   logic [ACC_WIDTH-1:0]          cmp_val_q, cmp_val_d;
`endif

   // FSM next state, address sweep counters and result capture
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      word_d  = word_q;
      cls_d   = cls_q;
      pred_d  = pred_q;
      score_d = score_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && write_done) begin
               state_d = S_RUN;
               addr_d  = '0;
               word_d  = '0;
               cls_d   = '0;
            end
         end
         S_RUN: begin
            if (addr_q == ADDR_WIDTH'(LAST_ADDR)) begin
               state_d = S_DRAIN;
               addr_d  = '0;
               word_d  = '0;
               cls_d   = '0;
            end else begin
               addr_d = addr_q + ADDR_WIDTH'(1);
               if (word_q == WORD_W'(WORDS_PER_CLASS - 1)) begin
                  word_d = '0;
                  cls_d  = cls_q + CLASS_WIDTH'(1);
               end else begin
                  word_d = word_q + WORD_W'(1);
               end
            end
         end
         S_DRAIN: begin
            // result outputs only move once the final class has been compared
            if (cmp_vld_q && cmp_last_q) begin
               state_d = S_DONE;
               pred_d  = best_cls_q;
               score_d = best_q;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // lane products summed in full precision; 20 bits cover 16 x (-128*-128)
   always_comb begin
      sum_d = '0;
      prod  = '0;
      for (int i = 0; i < M_SIZE; i++) begin
         prod  = $signed(class_out[i*FTWIDTH +: FTWIDTH]) * $signed(query_in[i*FTWIDTH +: FTWIDTH]);
         sum_d = sum_d + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
      end
   end

   // pipeline tags, per-class accumulation and running best
   always_comb begin
      v1_d       = re;
      first1_d   = (word_q == '0);
      last1_d    = (word_q == WORD_W'(WORDS_PER_CLASS - 1));
      cls1_d     = cls_q;
      v2_d       = v1_q;
      first2_d   = first1_q;
      last2_d    = last1_q;
      cls2_d     = cls1_q;
      acc_d      = acc_q;
      if (v2_q) begin
         // word 0 of a class restarts the score instead of adding to the old one
         if (first2_q) acc_d = {{(ACC_WIDTH-SUM_W){sum_q[SUM_W-1]}}, sum_q};
         else          acc_d = acc_q + {{(ACC_WIDTH-SUM_W){sum_q[SUM_W-1]}}, sum_q};
      end
      cmp_pend_d = v2_q && last2_q;
      cls3_d     = cls2_q;
      best_d     = best_q;
      best_cls_d = best_cls_q;
      // strict greater-than keeps the lowest index on ties; class 0 seeds best
      if (cmp_pend_q && ((cls3_q == '0) || (acc_q > best_q))) begin
         best_d     = acc_q;
         best_cls_d = cls3_q;
      end
      cmp_vld_d  = cmp_pend_q;
      cmp_last_d = (cls3_q == CLASS_WIDTH'(NUM_CLASSES - 1));
`ifdef ASSOC_SCORE_OUT_EN
      cmp_cls_d  = cls3_q;
      cmp_val_d  = acc_q;
`endif
   end

   // state and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         word_q     <= '0;
         cls_q      <= '0;
         v1_q       <= 1'b0;
         first1_q   <= 1'b0;
         last1_q    <= 1'b0;
         cls1_q     <= '0;
         v2_q       <= 1'b0;
         first2_q   <= 1'b0;
         last2_q    <= 1'b0;
         cls2_q     <= '0;
         sum_q      <= '0;
         acc_q      <= '0;
         cmp_pend_q <= 1'b0;
         cls3_q     <= '0;
         best_q     <= '0;
         best_cls_q <= '0;
         cmp_vld_q  <= 1'b0;
         cmp_last_q <= 1'b0;
         pred_q     <= '0;
         score_q    <= '0;
`ifdef ASSOC_SCORE_OUT_EN
         cmp_cls_q  <= '0;
         cmp_val_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         cls_q      <= cls_d;
         v1_q       <= v1_d;
         first1_q   <= first1_d;
         last1_q    <= last1_d;
         cls1_q     <= cls1_d;
         v2_q       <= v2_d;
         first2_q   <= first2_d;
         last2_q    <= last2_d;
         cls2_q     <= cls2_d;
         sum_q      <= sum_d;
         acc_q      <= acc_d;
         cmp_pend_q <= cmp_pend_d;
         cls3_q     <= cls3_d;
         best_q     <= best_d;
         best_cls_q <= best_cls_d;
         cmp_vld_q  <= cmp_vld_d;
         cmp_last_q <= cmp_last_d;
         pred_q     <= pred_d;
         score_q    <= score_d;
`ifdef ASSOC_SCORE_OUT_EN
         cmp_cls_q  <= cmp_cls_d;
         cmp_val_q  <= cmp_val_d;
`endif
      end
   end

   assign read_address  = addr_q;
   assign query_address = ADDR_WIDTH'(word_q);
   assign re            = (state_q == S_RUN);
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign pred_class    = pred_q;
   assign best_score    = score_q;
`ifdef ASSOC_SCORE_OUT_EN
   assign score_valid   = cmp_vld_q;
   assign score_class   = cmp_cls_q;
   assign score_value   = cmp_val_q;
`endif

endmodule
